// File: rtl/debug_evt_stretch_pkg.sv
// Shared encodings for the debug event conditioning stage: runtime view select
// and the per-channel stretch FSM states.
package debug_evt_stretch_pkg;

  typedef enum logic [1:0] {
    DBG_MODE_PASS    = 2'd0,
    DBG_MODE_STRETCH = 2'd1,
    DBG_MODE_TOGGLE  = 2'd2,
    DBG_MODE_HB      = 2'd3
  } dbg_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } ch_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debug_stretch_ch.sv
// One debug channel: stretches event strobes into fixed-width pulses with a forced gap, queueing close events.
// Latency: hold_nxt is the next-cycle level (registered by the parent). No backpressure: events past a full queue are dropped and flagged.
module debug_stretch_ch
  import debug_evt_stretch_pkg::*;
#(
  parameter int STRETCH_CYCLES = 1000,
  parameter int GAP_CYCLES     = 200,
  parameter int PEND_W         = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic evt,
  input  logic ovf_clr,
  output logic hold_nxt,
  output logic ovf
);

  localparam int CNT_W = $clog2(max_int(STRETCH_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0]  HOLD_LD  = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  ch_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              pend_inc, pend_dec, drop;
  logic              ovf_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_inc = 1'b0;
    pend_dec = 1'b0;
    case (state_q)
      IDLE: begin
        if (evt) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      HOLD: begin
        pend_inc = evt;
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          // An event landing on the last gap cycle starts the next pulse directly
          // when nothing is queued, otherwise it takes the slot just freed.
          pend_dec = (pend_q != '0);
          pend_inc = evt && (pend_q != '0);
          if ((pend_q != '0) || evt) begin
            state_d = HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          pend_inc = evt;
          cnt_d    = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    pend_d = pend_q;
    drop   = 1'b0;
    if (pend_inc && !pend_dec) begin
      if (pend_q == PEND_MAX) drop = 1'b1;
      else                    pend_d = pend_q + PEND_W'(1);
    end else if (pend_dec && !pend_inc) begin
      pend_d = pend_q - PEND_W'(1);
    end

    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      pend_d  = '0;
      drop    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end
  end

  assign hold_nxt = (state_d == HOLD);
  assign ovf      = ovf_q;

endmodule

// File: rtl/debug_evt_stretch.sv
// Conditions single-cycle debug event strobes for the header pins: pass, stretch, toggle or heartbeat view.
// Latency: 1 cycle evt_i to dbg_o in every mode. No backpressure: overflowing events are dropped and flagged on ovf_o.
module debug_evt_stretch
  import debug_evt_stretch_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int STRETCH_CYCLES = 1000,
  parameter int GAP_CYCLES     = 200,
  parameter int PEND_W         = 3,
  parameter int HB_HALF        = 500000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] evt_i,
  input  logic [1:0]      mode_i,
  input  logic            ovf_clr_i,
  output logic [N_CH-1:0] dbg_o,
  output logic [N_CH-1:0] ovf_o
);

  localparam int HB_W = $clog2(HB_HALF + 1);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_HALF - 1);

  logic [1:0]      mode_q;
  logic            mode_chg;
  logic [N_CH-1:0] ch_evt, hold_nxt;
  logic [N_CH-1:0] dbg_d, dbg_q;
  logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
  logic            hb_lvl_q, hb_lvl_d;

  // A mode change flushes all channel state; the event on that cycle is discarded.
  assign mode_chg = (mode_i != mode_q);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign ch_evt[i] = evt_i[i] & ~mode_chg &
                       ((mode_q == DBG_MODE_STRETCH) |
                        ((mode_q == DBG_MODE_HB) & (i != N_CH - 1)));

    debug_stretch_ch #(
      .STRETCH_CYCLES (STRETCH_CYCLES),
      .GAP_CYCLES     (GAP_CYCLES),
      .PEND_W         (PEND_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .clr      (mode_chg),
      .evt      (ch_evt[i]),
      .ovf_clr  (ovf_clr_i),
      .hold_nxt (hold_nxt[i]),
      .ovf      (ovf_o[i])
    );
  end

  always_comb begin
    hb_cnt_d = '0;
    hb_lvl_d = 1'b0;
    if (!mode_chg && (mode_q == DBG_MODE_HB)) begin
      if (hb_cnt_q == HB_LAST) begin
        hb_cnt_d = '0;
        hb_lvl_d = ~hb_lvl_q;
      end else begin
        hb_cnt_d = hb_cnt_q + HB_W'(1);
        hb_lvl_d = hb_lvl_q;
      end
    end
  end

  always_comb begin
    dbg_d = '0;
    if (!mode_chg) begin
      case (dbg_mode_e'(mode_q))
        DBG_MODE_PASS:    dbg_d = evt_i;
        DBG_MODE_STRETCH: dbg_d = hold_nxt;
        DBG_MODE_TOGGLE:  dbg_d = dbg_q ^ evt_i;
        default: begin
          dbg_d           = hold_nxt;
          dbg_d[N_CH-1]   = hb_lvl_d;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= DBG_MODE_PASS;
      dbg_q    <= '0;
      hb_cnt_q <= '0;
      hb_lvl_q <= 1'b0;
    end else begin
      mode_q   <= mode_i;
      dbg_q    <= dbg_d;
      hb_cnt_q <= hb_cnt_d;
      hb_lvl_q <= hb_lvl_d;
    end
  end

  assign dbg_o = dbg_q;

endmodule

// File: tb/tb_debug_evt_stretch.sv
// Bench for debug_evt_stretch: directed scenarios plus random traffic checked against a pulse-schedule model.
module tb_debug_evt_stretch;

  localparam int N    = 4;
  localparam int S    = 4;
  localparam int G    = 2;
  localparam int P    = 2;
  localparam int HB   = 3;
  localparam int PMAX = 3;
  localparam logic [1:0] M_PS = 2'd0, M_ST = 2'd1, M_TG = 2'd2, M_HB = 2'd3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] evt_i = '0;
  logic [1:0]   mode_i = M_PS;
  logic         ovf_clr_i = 1'b0;
  logic [N-1:0] dbg_o, ovf_o;

  always #5 clk = ~clk;

  debug_evt_stretch #(
    .N_CH(N), .STRETCH_CYCLES(S), .GAP_CYCLES(G), .PEND_W(P), .HB_HALF(HB)
  ) dut (
    .clk(clk), .rst(rst), .evt_i(evt_i), .mode_i(mode_i),
    .ovf_clr_i(ovf_clr_i), .dbg_o(dbg_o), .ovf_o(ovf_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: each channel is a schedule of pulse start times plus a queue depth.
  int           cyc;
  int           mode_m;
  int           cm;
  int           start   [N];
  int           free_at [N];
  int           pend    [N];
  logic [N-1:0] movf;
  logic [N-1:0] mlvl;
  logic [N-1:0] exp_dbg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    mode_m = 0;
    cyc    = 0;
    cm     = 0;
    movf   = '0;
    mlvl   = '0;
    for (int i = 0; i < N; i++) begin
      start[i]   = -1000;
      free_at[i] = -1000;
      pend[i]    = 0;
    end
  endtask

  task automatic step(input logic [N-1:0] e, input logic [1:0] m, input logic c);
    bit stretch;
    bit ovf_set;
    evt_i     = e;
    mode_i    = m;
    ovf_clr_i = c;
    if (int'(m) != mode_m) begin
      mode_m  = int'(m);
      cm      = cyc;
      mlvl    = '0;
      exp_dbg = '0;
      for (int i = 0; i < N; i++) begin
        start[i]   = -1000;
        free_at[i] = -1000;
        pend[i]    = 0;
        if (c) movf[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        stretch = (mode_m == 1) || (mode_m == 3 && i < N - 1);
        ovf_set = 1'b0;
        if (stretch) begin
          if (pend[i] > 0 && cyc + 1 == free_at[i]) begin
            start[i]   = cyc + 1;
            free_at[i] = cyc + 1 + S + G;
            pend[i]--;
          end
          if (e[i]) begin
            if (cyc + 1 >= free_at[i]) begin
              start[i]   = cyc + 1;
              free_at[i] = cyc + 1 + S + G;
            end else if (pend[i] == PMAX) begin
              ovf_set = 1'b1;
            end else begin
              pend[i]++;
            end
          end
        end
        movf[i] = ovf_set ? 1'b1 : (c ? 1'b0 : movf[i]);
        case (mode_m)
          0: exp_dbg[i] = e[i];
          2: begin
            mlvl[i]    = mlvl[i] ^ e[i];
            exp_dbg[i] = mlvl[i];
          end
          default: exp_dbg[i] = (start[i] <= cyc + 1) && (cyc + 1 < start[i] + S);
        endcase
        if (mode_m == 3 && i == N - 1) exp_dbg[i] = (((cyc - cm) / HB) % 2) != 0;
      end
    end
    @(posedge clk);
    #1;
    chk("dbg", dbg_o, exp_dbg);
    chk("ovf", ovf_o, movf);
    cyc++;
    evt_i     = '0;
    ovf_clr_i = 1'b0;
  endtask

  task automatic idle(input int n, input logic [1:0] m);
    for (int k = 0; k < n; k++) step('0, m, 1'b0);
  endtask

  task automatic do_reset();
    #2;
    rst       = 1'b1;
    evt_i     = '0;
    ovf_clr_i = 1'b0;
    #1;
    chk("rst_dbg", dbg_o, 0);
    chk("rst_ovf", ovf_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [1:0] rm;
    model_reset();
    do_reset();

    // single stretched pulse on ch0
    idle(10, M_ST);
    step(4'b0001, M_ST, 1'b0);
    idle(8, M_ST);

    // three close events on ch1 -> three spaced pulses
    step(4'b0010, M_ST, 1'b0);
    idle(1, M_ST);
    step(4'b0010, M_ST, 1'b0);
    step(4'b0010, M_ST, 1'b0);
    idle(20, M_ST);

    // saturate ch2, clear, then overflow together with clear
    repeat (5) step(4'b0100, M_ST, 1'b0);
    chk("ovf2_set", ovf_o[2], 1);
    idle(3, M_ST);
    step('0, M_ST, 1'b1);
    chk("ovf2_clr", ovf_o[2], 0);
    idle(25, M_ST);
    repeat (4) step(4'b0100, M_ST, 1'b0);
    step(4'b0100, M_ST, 1'b1);
    chk("ovf2_keep", ovf_o[2], 1);
    idle(30, M_ST);

    // toggle and pass views on ch3
    step('0, M_TG, 1'b0);
    idle(4, M_TG);
    step(4'b1000, M_TG, 1'b0);
    idle(3, M_TG);
    step(4'b1000, M_TG, 1'b0);
    idle(4, M_TG);
    step('0, M_PS, 1'b0);
    idle(4, M_PS);
    step(4'b1000, M_PS, 1'b0);
    idle(3, M_PS);
    step(4'b1000, M_PS, 1'b0);
    idle(4, M_PS);

    // heartbeat on ch3 with a stretched pulse on ch0
    step('0, M_HB, 1'b0);
    for (int j = 0; j < 12; j++) begin
      step((j == 0) ? 4'b0001 : 4'b0000, M_HB, 1'b0);
      if (j == 1) chk("hb_low", dbg_o[3], 0);
      if (j == 2) chk("hb_rise", dbg_o[3], 1);
    end

    // mode switch mid-HOLD keeps ovf, drops pulse, no replay
    step('0, M_ST, 1'b0);
    repeat (5) step(4'b0010, M_ST, 1'b0);
    chk("ovf1_set", ovf_o[1], 1);
    step('0, M_PS, 1'b0);
    chk("sw_dbg", dbg_o, 0);
    chk("sw_ovf1", ovf_o[1], 1);
    idle(10, M_PS);
    step('0, M_ST, 1'b0);
    idle(12, M_ST);

    // reset mid-HOLD
    step(4'b0001, M_ST, 1'b0);
    idle(1, M_ST);
    do_reset();
    idle(12, M_ST);

    // random traffic
    rm = M_ST;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 59) == 0) rm = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) do_reset();
      step(4'($urandom & $urandom), rm, ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
